// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, qualifies lock, releases the downstream reset and counts relocks.
// Optional RUN-state lock-loss glitch filter is enabled by defining PLL_LOCK_GLITCH_FILTER_EN.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYC = 100000,
    parameter int unsigned CNT_W            = 20,
    parameter int unsigned RELOCK_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pll_locked_i,
    input  logic                force_relock_i,
    output logic                pll_rst_o,
    output logic                sys_rst_n_o,
    output logic                lock_ok_o,
    output logic                timeout_err_o,
    output logic [RELOCK_W-1:0] relock_cnt_o
);

    // state     | meaning
    // RESET_PLL | pll_rst_o held high for RST_PULSE_CYC cycles
    // WAIT_LOCK | waiting for synced lock, bounded by LOCK_TIMEOUT_CYC
    // STABILIZE | counting consecutive synced-locked cycles
    // RUN       | lock qualified, downstream reset released, lock monitored
    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]    PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]    STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [RELOCK_W-1:0] RELOCK_MAX   = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             lk;
    logic             loss;

    // pll_locked_i is asynchronous to clk; only lk is used past this point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= pll_locked_i;
            lk    <= sync1;
        end
    end

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    logic [1:0] low_cnt;
    // loss on the fourth consecutive low cycle seen in RUN
    assign loss = !lk && (low_cnt == 2'd3);
`else
    assign loss = !lk;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RESET_PLL;
            cnt           <= '0;
            pll_rst_o     <= 1'b1;
            sys_rst_n_o   <= 1'b0;
            lock_ok_o     <= 1'b0;
            timeout_err_o <= 1'b0;
            relock_cnt_o  <= '0;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
            low_cnt       <= 2'd0;
`endif
        end else begin
            case (state)
                RESET_PLL: begin
                    if (cnt == PULSE_LAST) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        pll_rst_o <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state <= STABILIZE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state         <= RESET_PLL;
                        cnt           <= '0;
                        pll_rst_o     <= 1'b1;
                        timeout_err_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABILIZE: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= RUN;
                        cnt       <= '0;
                        lock_ok_o <= 1'b1;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
                        low_cnt   <= 2'd0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    // loss and a forced relock on the same cycle count once
                    if (loss || force_relock_i) begin
                        state       <= RESET_PLL;
                        cnt         <= '0;
                        pll_rst_o   <= 1'b1;
                        sys_rst_n_o <= 1'b0;
                        lock_ok_o   <= 1'b0;
                        if (relock_cnt_o != RELOCK_MAX) begin
                            relock_cnt_o <= relock_cnt_o + RELOCK_W'(1);
                        end
`ifdef PLL_LOCK_GLITCH_FILTER_EN
                        low_cnt     <= 2'd0;
`endif
                    end else begin
                        sys_rst_n_o <= 1'b1;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
                        low_cnt     <= lk ? 2'd0 : low_cnt + 2'd1;
`endif
                    end
                end
                default: begin
                    state       <= RESET_PLL;
                    cnt         <= '0;
                    pll_rst_o   <= 1'b1;
                    sys_rst_n_o <= 1'b0;
                    lock_ok_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Controls the reset/locked pair of a PLL instance from the consuming side. It pulses the PLL reset, waits for lock, and qualifies lock over a stability window before releasing the downstream system reset. It then monitors lock in operation, re-sequences on loss of lock or timeout, and counts relock events for status registers. It sits beside each PLL wrapper in the clock/reset tree and runs on the PLL reference (free-running) clock.

Parameters:
RST_PULSE_CYC, 16, cycles pll_rst_o is held high per reset attempt (min 1)
LOCK_STABLE_CYC, 1024, consecutive synced-locked cycles required before release (min 1)
LOCK_TIMEOUT_CYC, 100000, max cycles in WAIT_LOCK before retry (must be > LOCK_STABLE_CYC)
CNT_W, 20, width of shared cycle counter; must hold max(all *_CYC)
RELOCK_W, 8, width of relock event counter

Ports:
clk  in  1  free-running reference clock (same source as PLL refclk)
rst_n  in  1  asynchronous active-low reset
pll_locked_i  in  1  PLL locked output, asynchronous to clk
force_relock_i  in  1  single-cycle request to re-sequence the PLL
pll_rst_o  out  1  active-high reset to PLL
sys_rst_n_o  out  1  active-low reset to PLL-clocked logic, registered
lock_ok_o  out  1  high in RUN state
timeout_err_o  out  1  sticky: at least one WAIT_LOCK timeout since rst_n
relock_cnt_o  out  RELOCK_W  number of lock losses/forced relocks, saturating

Behaviour:
- Reset and synchronizer:
  - rst_n low (async): state=RESET_PLL, counter=0, pll_rst_o=1, sys_rst_n_o=0, lock_ok_o=0, timeout_err_o=0, relock_cnt_o=0.
  - Synchronizer flops clear to 0.
  - pll_locked_i passes through a 2-flop synchronizer; lk = second flop. Downstream logic uses lk only.
- FSM (one transition per clk; counter clears on every state entry):
  - RESET_PLL: pll_rst_o=1. After RST_PULSE_CYC cycles in state -> WAIT_LOCK.
  - WAIT_LOCK: pll_rst_o=0.
    - lk=1 -> STABILIZE.
    - Else if counter reaches LOCK_TIMEOUT_CYC-1 -> RESET_PLL and set timeout_err_o.
  - STABILIZE: count consecutive lk=1 cycles.
    - lk=0 -> WAIT_LOCK. Timeout counter restarts; no relock increment.
    - Count reaches LOCK_STABLE_CYC -> RUN.
  - RUN: lock_ok_o=1; sys_rst_n_o goes 1 on the cycle after RUN entry.
    - Loss detected (see Optional Feature) or force_relock_i=1 -> RESET_PLL and increment relock_cnt_o.
- Outputs: sys_rst_n_o=0 and lock_ok_o=0 on the same edge that leaves RUN.
- Latency: pll_locked_i rising to sys_rst_n_o high = 2 (sync) + 1 (WAIT_LOCK->STABILIZE) + LOCK_STABLE_CYC + 1 cycles, measured from the first clk edge that samples the high value.
- force_relock_i is ignored outside RUN.
- If force_relock_i and lock loss coincide in RUN: a single transition and a single increment.
- relock_cnt_o saturates at all-ones; no wrap.
- timeout_err_o clears only on rst_n.
- rst_n asserted mid-sequence: immediate return to the reset values above, including a mid-pulse or RUN state.

Optional Feature:
Macro PLL_LOCK_GLITCH_FILTER_EN.
- Defined: in RUN, loss is declared only after 4 consecutive lk=0 cycles. Shorter low glitches are ignored. The filter counter clears on any lk=1 and on RUN entry.
- Undefined: a single lk=0 cycle in RUN is a loss.
- All other behaviour is identical in both builds.

Test Plan:
Use RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32 for all scenarios.
1. Release rst_n, raise pll_locked_i 10 cycles later and hold -> pll_rst_o high for exactly 4 cycles; sys_rst_n_o rises 2+1+8+1=12 cycles after the locked edge; relock_cnt_o=0.
2. Hold pll_locked_i=0 -> pll_rst_o re-pulses every 4+32 cycles; timeout_err_o=1 after the first timeout and stays 1 after lock is later achieved.
3. During STABILIZE, drop pll_locked_i for 1 cycle at stable count 5 -> no release; the stability count restarts from 0; the full 8-cycle window is required.
4. In RUN, drop pll_locked_i for 2 cycles:
   - Without PLL_LOCK_GLITCH_FILTER_EN: sys_rst_n_o falls, relock_cnt_o=1.
   - With the macro: no effect. A 4-cycle drop causes the loss.
5. In RUN, pulse force_relock_i 300 times with lock held -> relock_cnt_o saturates at 255. force_relock_i pulsed in WAIT_LOCK has no effect.
6. Assert rst_n low during RUN and during a RESET_PLL pulse -> all outputs take reset values asynchronously (before the next clk edge); the sequence restarts on release.
